pixel_frame_sequencer: RTL and testbench

//  Sequences a whole-frame per-byte pixel transform: raster-scans a source frame buffer (line, pixel, channel),

---
 rtl/pixel_seq_pkg.sv | 25 ++
 rtl/pixel_skid_buf.sv | 57 +++++
 rtl/pixel_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_seq_pkg.sv
// Shared types and constants for the frame sequencer.
// Per-byte pixel transform helper lives here so bench and RTL agree on it.
package pixel_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    localparam logic [2:0] CH_GRAY = 3'd1;
    localparam logic [2:0] CH_RGB  = 3'd3;
    localparam logic [2:0] CH_RGBA = 3'd4;
    localparam logic [7:0] PIX_MAX = 8'hFF;

    function automatic logic [7:0] pix_xform(
        input logic [7:0] d,
        input logic       pass
    );
        return pass ? d : PIX_MAX - d;
    endfunction

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry {addr,data} FIFO between read capture and the write port.
// Synchronous flush empties it in one cycle (used on abort).
module pixel_skid_buf #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [7:0]        push_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [7:0]        head_data,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] addr_q [2];
    logic [7:0]        data_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              do_push;
    logic              do_pop;

    assign full      = (cnt == 2'd2);
    assign empty     = (cnt == 2'd0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '{default: '0};
            data_q <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Raster-scans a source frame, inverts each byte, writes it to a destination.
// Define ALPHA_PASS_EN to pass the alpha byte of 4-channel frames unmodified.
module pixel_frame_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [2:0]        cfg_channel,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic [ADDR_W-1:0] byte_cnt
);

    seq_state_t        state, state_nx;
    logic [DIM_W-1:0]  width_q, height_q, pxl_q, line_q;
    logic [2:0]        chan_q, dpt_q;
    logic [ADDR_W-1:0] src_q, dst_q, total_q, issued_q, cnt_q;
    logic [ADDR_W-1:0] cap_addr_q, head_addr;
    logic [7:0]        head_data;
    logic              in_flight_q, cap_pass_q, err_q;
    logic              accept, stop, cfg_bad, pop, pass_now;
    logic              sb_full, sb_empty;
    logic [2:0]        pending;

    assign accept  = (state == IDLE) && start && !abort;
    assign stop    = abort && (state == RUN || state == DRAIN);
    assign cfg_bad = (width_q == '0) || (height_q == '0) ||
                     !(chan_q inside {CH_GRAY, CH_RGB, CH_RGBA});

`ifdef ALPHA_PASS_EN
    assign pass_now = (chan_q == CH_RGBA) && (dpt_q == 3'd3);
`else
    assign pass_now = 1'b0;
`endif

    assign wr_en = !sb_empty;
    assign pop   = wr_en && wr_ready;

    // Slot freed by this cycle's pop is reusable, giving 1 byte/cycle.
    assign pending = {2'b0, in_flight_q}
                   + (sb_full ? 3'd2 : (sb_empty ? 3'd0 : 3'd1))
                   - {2'b0, pop};
    assign rd_en   = (state == RUN) && !abort &&
                     (issued_q < total_q) && (pending < 3'd2);

    assign rd_addr  = src_q + issued_q;
    assign wr_addr  = wr_en ? head_addr : '0;
    assign wr_data  = wr_en ? head_data : 8'h00;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err_cfg  = err_q;
    assign byte_cnt = cnt_q;

    pixel_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_flight_q),
        .pop       (pop),
        .flush     (stop),
        .push_addr (cap_addr_q),
        .push_data (pix_xform(rd_data, cap_pass_q)),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (sb_full),
        .empty     (sb_empty)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = CHECK;
            CHECK:   state_nx = cfg_bad ? DONE : RUN;
            RUN: begin
                if (abort)
                    state_nx = DONE;
                else if (issued_q == total_q)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort)
                    state_nx = DONE;
                else if (cnt_q == total_q && sb_empty && !in_flight_q)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            chan_q      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            cnt_q       <= '0;
            dpt_q       <= '0;
            pxl_q       <= '0;
            line_q      <= '0;
            in_flight_q <= 1'b0;
            cap_addr_q  <= '0;
            cap_pass_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            in_flight_q <= rd_en;
            if (accept) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                chan_q   <= cfg_channel;
                src_q    <= src_base;
                dst_q    <= dst_base;
                err_q    <= 1'b0;
                cnt_q    <= '0;
                issued_q <= '0;
                dpt_q    <= '0;
                pxl_q    <= '0;
                line_q   <= '0;
            end
            if (state == CHECK) begin
                total_q <= ADDR_W'(width_q) * ADDR_W'(height_q)
                         * ADDR_W'(chan_q);
                if (cfg_bad)
                    err_q <= 1'b1;
            end
            if (rd_en) begin
                cap_addr_q <= dst_q + issued_q;
                cap_pass_q <= pass_now;
                issued_q   <= issued_q + 1'b1;
                if (dpt_q == chan_q - 3'd1) begin
                    dpt_q <= '0;
                    if (pxl_q == width_q - DIM_W'(1)) begin
                        pxl_q  <= '0;
                        line_q <= (line_q == height_q - DIM_W'(1))
                                ? '0 : line_q + DIM_W'(1);
                    end else begin
                        pxl_q <= pxl_q + DIM_W'(1);
                    end
                end else begin
                    dpt_q <= dpt_q + 3'd1;
                end
            end
            if (pop)
                cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer: expected writes are queued
// at frame start and matched against accepted writes seen by the monitor.
module tb_pixel_frame_sequencer;

    localparam int ADDR_W = 24;
    localparam int DIM_W  = 16;
    localparam int EW     = ADDR_W + 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DIM_W-1:0]  cfg_width = '0;
    logic [DIM_W-1:0]  cfg_height = '0;
    logic [2:0]        cfg_channel = '0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready = 1'b1;
    logic              busy, done, err_cfg;
    logic [ADDR_W-1:0] byte_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0]    src_mem [0:4095];
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] obs_q [$];

    int rd_seen = 0;
    int wen_seen = 0;
    int done_seen = 0;
    int viol_out = 0;
    int viol_stall = 0;

    pixel_frame_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_channel (cfg_channel),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rd_en)
            rd_data <= src_mem[rd_addr[11:0]];

    initial begin : monitor
        int            outst;
        logic          prev_stall;
        logic [EW-1:0] prev_w;
        outst      = 0;
        prev_stall = 1'b0;
        prev_w     = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                outst      = 0;
                prev_stall = 1'b0;
            end else begin
                if (rd_en) rd_seen++;
                if (wr_en) wen_seen++;
                if (done) done_seen++;
                if (prev_stall && (!wr_en || {wr_addr, wr_data} !== prev_w))
                    viol_stall++;
                prev_stall = wr_en && !wr_ready;
                prev_w     = {wr_addr, wr_data};
                if (wr_en && wr_ready)
                    obs_q.push_back({wr_addr, wr_data});
                outst = outst + int'(rd_en) - int'(wr_en && wr_ready);
                if (outst > 2) viol_out++;
                if (done || abort) outst = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h, input int ch,
                               input logic [ADDR_W-1:0] s,
                               input logic [ADDR_W-1:0] d);
        logic [7:0] b, e;
        cfg_width   = DIM_W'(w);
        cfg_height  = DIM_W'(h);
        cfg_channel = 3'(ch);
        src_base    = s;
        dst_base    = d;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        if (w > 0 && h > 0 && (ch == 1 || ch == 3 || ch == 4)) begin
            for (int i = 0; i < w * h * ch; i++) begin
                b = src_mem[12'(s + ADDR_W'(i))];
                e = 8'hFF - b;
`ifdef ALPHA_PASS_EN
                if (ch == 4 && (i % 4) == 3) e = b;
`endif
                exp_q.push_back({ADDR_W'(d + ADDR_W'(i)), e});
            end
        end
    endtask

    task automatic wait_done(input int budget, input bit toggle,
                             output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget && !ok) begin
            @(posedge clk);
            #1;
            if (toggle) wr_ready = ~wr_ready;
            @(negedge clk);
            cyc++;
            if (done) ok = 1'b1;
        end
        #1;
        wr_ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, rd_en, wr_en, err_cfg} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=00000",
                     {busy, done, rd_en, wr_en, err_cfg});
        end
        total++;
        if ({byte_cnt, wr_addr, wr_data, rd_addr} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0",
                     {byte_cnt, wr_addr, wr_data, rd_addr});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, rd_en, wr_en} !== 3'b0) begin
            bad++;
            $display("FAIL post_reset_idle got=%b exp=000",
                     {busy, rd_en, wr_en});
        end
    endtask

    task automatic test_frame;
        int base, r0, d0, cyc;
        bit ok;
        logic [EW-1:0] e;
        base = obs_q.size();
        r0   = rd_seen;
        d0   = done_seen;
        start_frame(4, 2, 3, 24'h000, 24'h100);
        wait_done(100, 1'b0, cyc, ok);
        total++;
        if (!ok || cyc != 28) begin
            bad++;
            $display("FAIL frame_latency got=%0d exp=28 ok=%0b", cyc, ok);
        end
        total++;
        if (obs_q.size() - base != 24 || rd_seen - r0 != 24) begin
            bad++;
            $display("FAIL frame_count wr=%0d rd=%0d exp=24",
                     obs_q.size() - base, rd_seen - r0);
        end
        for (int i = base; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL frame_wr[%0d] got=%h exp=%h", i - base, obs_q[i], e);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (done_seen - d0 != 1 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_done pulses=%0d done=%b busy=%b exp=1,0,0",
                     done_seen - d0, done, busy);
        end
        total++;
        if (byte_cnt !== 24'd24) begin
            bad++;
            $display("FAIL frame_byte_cnt got=%0d exp=24", byte_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_stall;
        int base, vs, vo, cyc;
        bit ok;
        logic [EW-1:0] e;
        base = obs_q.size();
        vs   = viol_stall;
        vo   = viol_out;
        start_frame(4, 2, 3, 24'h000, 24'h100);
        wait_done(200, 1'b1, cyc, ok);
        total++;
        if (!ok || obs_q.size() - base != 24) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=24 ok=%0b",
                     obs_q.size() - base, ok);
        end
        for (int i = base; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL stall_wr[%0d] got=%h exp=%h", i - base, obs_q[i], e);
            end
        end
        total++;
        if (viol_stall - vs != 0) begin
            bad++;
            $display("FAIL stall_stable got=%0d exp=0", viol_stall - vs);
        end
        total++;
        if (viol_out - vo != 0) begin
            bad++;
            $display("FAIL outstanding got=%0d exp=0", viol_out - vo);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_bad_cfg;
        int r0, w0, cyc;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            r0 = rd_seen;
            w0 = wen_seen;
            if (k == 0) start_frame(0, 2, 3, 24'h0, 24'h100);
            else        start_frame(2, 2, 2, 24'h0, 24'h100);
            wait_done(3, 1'b0, cyc, ok);
            total++;
            if (!ok || err_cfg !== 1'b1) begin
                bad++;
                $display("FAIL bad_cfg%0d done=%0b err=%b exp=1,1", k, ok, err_cfg);
            end
            total++;
            if (rd_seen != r0 || wen_seen != w0) begin
                bad++;
                $display("FAIL bad_cfg%0d_mem rd=%0d wr=%0d exp=0,0",
                         k, rd_seen - r0, wen_seen - w0);
            end
            repeat (2) tick();
            total++;
            if (err_cfg !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL bad_cfg%0d_sticky err=%b busy=%b exp=1,0",
                         k, err_cfg, busy);
            end
        end
    endtask

    task automatic test_alpha;
        int base, cyc;
        bit ok;
        logic [EW-1:0] e;
        for (int i = 0; i < 16; i++)
            src_mem[12'h200 + 12'(i)] = ((i % 4) == 3) ? 8'h80 : 8'(i * 5 + 1);
        base = obs_q.size();
        start_frame(2, 2, 4, 24'h200, 24'h400);
        wait_done(100, 1'b0, cyc, ok);
        total++;
        if (!ok || err_cfg !== 1'b0 || obs_q.size() - base != 16) begin
            bad++;
            $display("FAIL alpha_frame ok=%0b err=%b wr=%0d exp=1,0,16",
                     ok, err_cfg, obs_q.size() - base);
        end
        for (int i = base; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL alpha_wr[%0d] got=%h exp=%h", i - base, obs_q[i], e);
            end
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_abort;
        int base, d0, cyc, n;
        bit ok;
        logic extra;
        logic [EW-1:0] e;
        base = obs_q.size();
        start_frame(16, 16, 1, 24'h300, 24'h800);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (byte_cnt !== 24'd5 && n < 100);
        d0    = done_seen;
        abort = 1'b1;
        #1;
        extra = wr_en && wr_ready;
        total++;
        if (n >= 100 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL abort_rd_en got=%b exp=0 n=%0d", rd_en, n);
        end
        tick();
        abort = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1 || done_seen - d0 != 1) begin
            bad++;
            $display("FAIL abort_done got=%b exp=1", done);
        end
        total++;
        if (byte_cnt !== 24'd5 + 24'(extra) || obs_q.size() - base != int'(byte_cnt)) begin
            bad++;
            $display("FAIL abort_byte_cnt got=%0d exp=%0d obs=%0d",
                     byte_cnt, 5 + int'(extra), obs_q.size() - base);
        end
        for (int i = base; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL abort_wr[%0d] got=%h exp=%h", i - base, obs_q[i], e);
            end
        end
        exp_q.delete();
        tick();
        base = obs_q.size();
        start_frame(3, 1, 1, 24'h010, 24'h900);
        wait_done(50, 1'b0, cyc, ok);
        total++;
        if (!ok || obs_q.size() - base != 3 || byte_cnt !== 24'd3) begin
            bad++;
            $display("FAIL restart ok=%0b wr=%0d cnt=%0d exp=1,3,3",
                     ok, obs_q.size() - base, byte_cnt);
        end
        for (int i = base; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL restart_wr[%0d] got=%h exp=%h", i - base, obs_q[i], e);
            end
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_start_busy_reset;
        int base, d0, cyc;
        bit ok;
        logic [EW-1:0] e;
        base = obs_q.size();
        d0   = done_seen;
        start_frame(4, 2, 3, 24'h000, 24'h100);
        repeat (3) tick();
        cfg_width   = 16'd1;
        cfg_channel = 3'd1;
        src_base    = 24'h050;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        wait_done(100, 1'b0, cyc, ok);
        total++;
        if (!ok || obs_q.size() - base != 24) begin
            bad++;
            $display("FAIL busy_start_count got=%0d exp=24", obs_q.size() - base);
        end
        for (int i = base; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL busy_start_wr[%0d] got=%h exp=%h",
                         i - base, obs_q[i], e);
            end
        end
        exp_q.delete();
        repeat (4) tick();
        total++;
        if (busy !== 1'b0 || done_seen - d0 != 1) begin
            bad++;
            $display("FAIL busy_start_ignored busy=%b pulses=%0d exp=0,1",
                     busy, done_seen - d0);
        end
        start_frame(16, 16, 1, 24'h300, 24'h800);
        repeat (10) tick();
        d0      = done_seen;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, rd_en, wr_en, err_cfg} !== 5'b0 ||
            {byte_cnt, wr_addr, wr_data, rd_addr} !== '0) begin
            bad++;
            $display("FAIL midrun_reset ctl=%b data=%h exp=0",
                     {busy, done, rd_en, wr_en, err_cfg},
                     {byte_cnt, wr_addr, wr_data, rd_addr});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (done_seen != d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done pulses=%0d busy=%b exp=0,0",
                     done_seen - d0, busy);
        end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            src_mem[i] = 8'((i * 37 + 11) & 255);
        test_reset();
        test_frame();
        test_stall();
        test_bad_cfg();
        test_alpha();
        test_abort();
        test_start_busy_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
